// File: rtl/pipeline_drain_controller_pkg.sv
// Shared definitions for the 5-stage pipeline drain/stall controller.
// Holds the controller state encoding, the inter-stage register indices,
// the bundle of per-cycle enable/flush strobes, and the valid-bit update rule.
package pipeline_drain_controller_pkg;

  // Four inter-stage registers sit between the five stages
  localparam int NUM_REGS = 4;

  // Inter-stage register indices, upstream first
  localparam int IF_ID   = 0;
  localparam int ID_EXE  = 1;
  localparam int EXE_MEM = 2;
  localparam int MEM_WB  = 3;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  // One cycle's worth of register enables and bubble-insert strobes
  typedef struct packed {
    logic pc_ena;
    logic if_id_ena;
    logic id_exe_ena;
    logic exe_mem_ena;
    logic mem_wb_ena;
    logic if_id_flush;
    logic id_exe_flush;
    logic mem_wb_flush;
  } ctrl_t;

  // Valid bits after one clock: a disabled register holds, a bubble-loaded
  // register goes empty, IF/ID takes a fresh fetch, the rest copy upstream.
  function automatic logic [NUM_REGS-1:0] next_valid(
    input logic [NUM_REGS-1:0] valid,
    input logic [NUM_REGS-1:0] load,
    input logic [NUM_REGS-1:0] bubble
  );
    logic [NUM_REGS-1:0] nv;
    nv = valid;
    if (load[IF_ID])   nv[IF_ID]   = ~bubble[IF_ID];
    if (load[ID_EXE])  nv[ID_EXE]  = bubble[ID_EXE]  ? 1'b0 : valid[IF_ID];
    if (load[EXE_MEM]) nv[EXE_MEM] = bubble[EXE_MEM] ? 1'b0 : valid[ID_EXE];
    if (load[MEM_WB])  nv[MEM_WB]  = bubble[MEM_WB]  ? 1'b0 : valid[EXE_MEM];
    return nv;
  endfunction

endpackage

// File: rtl/pipeline_drain_controller_perf.sv
// Enable-gated 32-bit wrapping event counter for pipeline statistics.
// Only built when PIPE_PERF_CNT_EN is defined; otherwise the controller
// ties its counter outputs to zero and this module does not exist.
`ifdef PIPE_PERF_CNT_EN
module pipeline_perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  // Count one per enabled cycle, rolling over from all-ones back to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 32'd0;
    end else if (inc_i) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/pipeline_drain_controller.sv
// Hazard-aware stage-enable generator for the IF/ID/EXE/MEM/WB pipeline.
// Produces PC and inter-stage register enables plus bubble strobes in
// response to load-use, mult/div-busy and taken-branch hazards, and drains
// the pipeline to an empty, halted state on request.
// Optional build macro: PIPE_PERF_CNT_EN adds stall-cycle and flush counters.
module pipeline_drain_controller
  import pipeline_drain_controller_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                ena_i,
  input  logic                load_use_i,
  input  logic                md_busy_i,
  input  logic                branch_taken_i,
  input  logic                halt_req_i,
  input  logic                resume_i,
  output logic                pc_ena_o,
  output logic                if_id_ena_o,
  output logic                id_exe_ena_o,
  output logic                exe_mem_ena_o,
  output logic                mem_wb_ena_o,
  output logic                if_id_flush_o,
  output logic                id_exe_flush_o,
  output logic                mem_wb_flush_o,
  output logic [NUM_REGS-1:0] stage_valid_o,
  output logic                halted_o,
  output logic [31:0]         stall_cycles_o,
  output logic [31:0]         flush_count_o
);

  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] valid_q, valid_d;
  logic                halted_q, halted_d;
  ctrl_t               ctrl;
  logic                pipe_empty;

  assign pipe_empty = (valid_q == '0);

  // Zero-latency stall/flush response and next-state selection
  always_comb begin
    ctrl     = '0;
    state_d  = state_q;
    halted_d = halted_q;
    case (state_q)
      IDLE: begin
        if (ena_i) state_d = RUN;
      end
      RUN: begin
        if (!ena_i) begin
          ctrl = '0;
        end else if (md_busy_i) begin
          // EXE is occupied: freeze everything upstream, retire a bubble into WB
          ctrl.mem_wb_ena   = 1'b1;
          ctrl.mem_wb_flush = 1'b1;
        end else if (load_use_i) begin
          // Hold IF and ID, slip a bubble into EXE; a same-cycle branch is dropped
          ctrl.id_exe_ena   = 1'b1;
          ctrl.id_exe_flush = 1'b1;
          ctrl.exe_mem_ena  = 1'b1;
          ctrl.mem_wb_ena   = 1'b1;
        end else begin
          ctrl.pc_ena      = 1'b1;
          ctrl.if_id_ena   = 1'b1;
          ctrl.id_exe_ena  = 1'b1;
          ctrl.exe_mem_ena = 1'b1;
          ctrl.mem_wb_ena  = 1'b1;
          ctrl.if_id_flush = branch_taken_i;
          if (halt_req_i) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!ena_i) begin
          ctrl = '0;
        end else if (pipe_empty) begin
          // Nothing left in flight: stop touching registers and report halted
          state_d  = HALTED;
          halted_d = 1'b1;
        end else if (md_busy_i) begin
          ctrl.mem_wb_ena   = 1'b1;
          ctrl.mem_wb_flush = 1'b1;
        end else begin
          // No new fetch; bubbles enter at IF/ID while older work retires
          ctrl.if_id_ena   = 1'b1;
          ctrl.if_id_flush = 1'b1;
          ctrl.id_exe_ena  = 1'b1;
          ctrl.exe_mem_ena = 1'b1;
          ctrl.mem_wb_ena  = 1'b1;
        end
      end
      HALTED: begin
        if (resume_i && !halt_req_i) begin
          state_d  = RUN;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        halted_d = 1'b0;
      end
    endcase
  end

  // Track which inter-stage registers hold a real instruction
  always_comb begin
    valid_d = next_valid(
      valid_q,
      {ctrl.mem_wb_ena, ctrl.exe_mem_ena, ctrl.id_exe_ena, ctrl.if_id_ena},
      {ctrl.mem_wb_flush, 1'b0, ctrl.id_exe_flush, ctrl.if_id_flush}
    );
  end

  // Controller state, occupancy and halted flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign pc_ena_o       = ctrl.pc_ena;
  assign if_id_ena_o    = ctrl.if_id_ena;
  assign id_exe_ena_o   = ctrl.id_exe_ena;
  assign exe_mem_ena_o  = ctrl.exe_mem_ena;
  assign mem_wb_ena_o   = ctrl.mem_wb_ena;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_exe_flush_o = ctrl.id_exe_flush;
  assign mem_wb_flush_o = ctrl.mem_wb_flush;
  assign stage_valid_o  = valid_q;
  assign halted_o       = halted_q;

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = ((state_q == RUN) || (state_q == DRAIN)) && ena_i &&
                     (md_busy_i || load_use_i);
  assign flush_inc = ctrl.if_id_flush | ctrl.id_exe_flush | ctrl.mem_wb_flush;

  pipeline_perf_counter u_stall_counter (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (stall_inc),
    .count_o (stall_cycles_o)
  );

  pipeline_perf_counter u_flush_counter (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (flush_inc),
    .count_o (flush_count_o)
  );
`else
  assign stall_cycles_o = 32'd0;
  assign flush_count_o  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_drain_controller.sv
// Self-checking bench for pipeline_drain_controller.
// The reference model follows individual instructions through the four
// inter-stage registers by ID number (0 = bubble) and derives the expected
// strobes, occupancy, halted flag and counters from the pipeline rules.
module tb_pipeline_drain_controller;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_DRAIN  = 2;
  localparam int M_HALTED = 3;

  localparam int A_NONE  = 0;
  localparam int A_MD    = 1;
  localparam int A_LU    = 2;
  localparam int A_ADV   = 3;
  localparam int A_DRAIN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ena = 1'b0;
  logic        loadUse = 1'b0;
  logic        mdBusy = 1'b0;
  logic        branchTaken = 1'b0;
  logic        haltReq = 1'b0;
  logic        resume = 1'b0;
  logic        pcEna, ifIdEna, idExeEna, exeMemEna, memWbEna;
  logic        ifIdFlush, idExeFlush, memWbFlush;
  logic [3:0]  stageValid;
  logic        halted;
  logic [31:0] stallCycles, flushCount;
  logic [7:0]  dutCtrl;

  int          testCount = 0;
  int          failCount = 0;

  int          mode;
  int          slot[4];
  int          nextId;
  logic        expHalted;
  logic [31:0] expStall;
  logic [31:0] expFlush;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  pipeline_drain_controller dut (
    .clk            (clk),
    .reset          (reset),
    .ena_i          (ena),
    .load_use_i     (loadUse),
    .md_busy_i      (mdBusy),
    .branch_taken_i (branchTaken),
    .halt_req_i     (haltReq),
    .resume_i       (resume),
    .pc_ena_o       (pcEna),
    .if_id_ena_o    (ifIdEna),
    .id_exe_ena_o   (idExeEna),
    .exe_mem_ena_o  (exeMemEna),
    .mem_wb_ena_o   (memWbEna),
    .if_id_flush_o  (ifIdFlush),
    .id_exe_flush_o (idExeFlush),
    .mem_wb_flush_o (memWbFlush),
    .stage_valid_o  (stageValid),
    .halted_o       (halted),
    .stall_cycles_o (stallCycles),
    .flush_count_o  (flushCount)
  );

  assign dutCtrl = {pcEna, ifIdEna, idExeEna, exeMemEna, memWbEna,
                    ifIdFlush, idExeFlush, memWbFlush};

  // Compare one observed value against the model's expectation
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Occupancy as the model sees it
  function automatic logic [3:0] modelValid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (slot[i] != 0);
    return v;
  endfunction

  // Compare all registered outputs against the model
  task automatic checkRegistered(input string prefix);
    checkOutput({prefix, "_valid"}, {28'd0, stageValid}, {28'd0, modelValid()});
    checkOutput({prefix, "_halted"}, {31'd0, halted}, {31'd0, expHalted});
    checkOutput({prefix, "_stall"}, stallCycles, expStall);
    checkOutput({prefix, "_flush"}, flushCount, expFlush);
  endtask

  // Assert reset between clock edges and expect an immediate clean slate
  task automatic resetDut();
    @(negedge clk);
    #2;
    reset = 1'b0;
    ena = 1'b0; loadUse = 1'b0; mdBusy = 1'b0;
    branchTaken = 1'b0; haltReq = 1'b0; resume = 1'b0;
    #1;
    mode = M_IDLE;
    for (int i = 0; i < 4; i++) slot[i] = 0;
    nextId = 1;
    expHalted = 1'b0;
    expStall = 32'd0;
    expFlush = 32'd0;
    checkOutput("rst_ctrl", {24'd0, dutCtrl}, 32'd0);
    checkRegistered("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive one cycle of hazard inputs, check strobes, then check the result
  task automatic applyStimulus(input logic e, input logic lu, input logic md,
                               input logic br, input logic hr, input logic rs);
    int         act;
    bit         empty;
    logic [7:0] expCtrl;
    @(negedge clk);
    ena = e; loadUse = lu; mdBusy = md;
    branchTaken = br; haltReq = hr; resume = rs;
    #1;
    empty = (slot[0] == 0) && (slot[1] == 0) && (slot[2] == 0) && (slot[3] == 0);

    act = A_NONE;
    if (e && mode == M_RUN) act = md ? A_MD : (lu ? A_LU : A_ADV);
    else if (e && mode == M_DRAIN && !empty) act = md ? A_MD : A_DRAIN;

    case (act)
      A_MD:    expCtrl = 8'b00001_001;
      A_LU:    expCtrl = 8'b00111_010;
      A_ADV:   expCtrl = {5'b11111, br, 2'b00};
      A_DRAIN: expCtrl = 8'b01111_100;
      default: expCtrl = 8'b00000_000;
    endcase
    checkOutput("ctrl", {24'd0, dutCtrl}, {24'd0, expCtrl});

`ifdef PIPE_PERF_CNT_EN
    if ((mode == M_RUN || mode == M_DRAIN) && e && (md || lu)) expStall = expStall + 32'd1;
    if (expCtrl[2:0] != 3'b000) expFlush = expFlush + 32'd1;
`endif

    // Move instructions through the pipe according to what happened
    case (act)
      A_MD: slot[3] = 0;
      A_LU: begin
        slot[3] = slot[2];
        slot[2] = slot[1];
        slot[1] = 0;
      end
      A_ADV, A_DRAIN: begin
        slot[3] = slot[2];
        slot[2] = slot[1];
        slot[1] = slot[0];
        if (act == A_ADV && !br) begin
          slot[0] = nextId;
          nextId++;
        end else begin
          slot[0] = 0;
        end
      end
      default: ;
    endcase

    case (mode)
      M_IDLE:   if (e) mode = M_RUN;
      M_RUN:    if (act == A_ADV && hr) mode = M_DRAIN;
      M_DRAIN:  if (e && empty) begin mode = M_HALTED; expHalted = 1'b1; end
      M_HALTED: if (rs && !hr) begin mode = M_RUN; expHalted = 1'b0; end
      default:  mode = M_IDLE;
    endcase

    @(posedge clk);
    #1;
    checkRegistered("cyc");
  endtask

  initial begin
    mode = M_IDLE;
    nextId = 1;
    for (int i = 0; i < 4; i++) slot[i] = 0;
    expHalted = 1'b0;
    expStall = 32'd0;
    expFlush = 32'd0;

    $display("[TB] starting pipeline_drain_controller bench");
    resetDut();

    // Fill from IDLE
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    // Load-use with a simultaneous branch, then refill
    applyStimulus(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    // Three cycles of mult/div occupancy
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    // Drain a full pipeline to HALTED
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0, 1, 0);
    // Resume while halt still requested must not leave HALTED
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    // Enter DRAIN, retire two bubbles, then reset mid-drain
    applyStimulus(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    resetDut();

    // Randomised traffic with occasional mid-run resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        resetDut();
      end else begin
        applyStimulus($urandom_range(0, 9) != 0,
                      $urandom_range(0, 6) == 0,
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 4) == 0,
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 3) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
